// File: rtl/user_counter_ctrl.sv
// -----------------------------------------------------------------------------
// user_counter_ctrl
//
// Control and arbitration front-end for the user-area counter datapath.
// Sequences the counter with a prescaler, arbitrates counter loads between the
// Wishbone LOAD register and the LA load port, raises a compare-match IRQ and
// drives the shared GPIO output enables.
//
// Build option:
//   USER_COUNTER_CTRL_DIGIT_EN  when defined, digit0_out is a registered hex
//                               7-segment decode of count_o[3:0]. When
//                               undefined, the digit outputs are tied off.
//
// Ports:
//   wb_clk_i, wb_rst_i    clock, synchronous active-high reset
//   wbs_*                 Wishbone slave (single-cycle registered ack)
//   la_load_req/val       LA load request (rising edge) and load value
//   count_o, count_oeb    counter value and active-low GPIO enables
//   digit_pol_in          7-seg polarity (1 = active-low segments)
//   digit0_out/oeb        7-seg pattern (gfedcba) and active-low enables
//   irq_o                 compare-match interrupt
//
// Wishbone handshake: an access is cyc & stb & base-address match while ack is
// low. ack is registered, rises on the cycle after the access and stays high
// for exactly one cycle; write side effects and read data are registered on
// the same edge that raises ack.
//
// Register map (word offsets): 0x00 CTRL {out_en, auto_reload, irq_en, down,
// en}, 0x04 PRESC, 0x08 LOAD (write also requests a load), 0x0C CMP,
// 0x10 STATUS {pending[17], match[16] W1C, count}.
// -----------------------------------------------------------------------------
module user_counter_ctrl #(
  parameter int          BITS      = 16,
  parameter logic [23:0] ADDR_BASE = 24'h300000
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic            la_load_req,
  input  logic [BITS-1:0] la_load_val,
  output logic [BITS-1:0] count_o,
  output logic [BITS-1:0] count_oeb,
  input  logic            digit_pol_in,
  output logic [6:0]      digit0_out,
  output logic [6:0]      digit0_oeb,
  output logic            irq_o
);

  localparam logic [BITS-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD_LA = 2'd1,
    ST_LOAD_WB = 2'd2
  } load_state_e;

  // Register state
  logic [4:0]      ctrl_q,    ctrl_d;
  logic [15:0]     presc_q,   presc_d;
  logic [BITS-1:0] load_q,    load_d;
  logic [BITS-1:0] cmp_q,     cmp_d;
  logic            match_q,   match_d;
  logic            pending_q, pending_d;
  load_state_e     state_q,   state_d;
  logic [BITS-1:0] la_val_q,  la_val_d;
  logic            la_req_q,  la_req_d;
  logic [15:0]     pcnt_q,    pcnt_d;
  logic [BITS-1:0] count_q,   count_d;
  logic            ack_q,     ack_d;
  logic [31:0]     dat_q,     dat_d;
  logic            irq_q,     irq_d;

  // Decode
  logic        access, wr, rd;
  logic [2:0]  reg_sel;
  logic [15:0] be_mask;
  logic        wb_load_req, la_edge;
  logic [31:0] rd_data;

  logic en, down, irq_en, auto_reload, out_en;
  assign en          = ctrl_q[0];
  assign down        = ctrl_q[1];
  assign irq_en      = ctrl_q[2];
  assign auto_reload = ctrl_q[3];
  assign out_en      = ctrl_q[4];

  always_comb begin
    access      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == ADDR_BASE) & ~ack_q;
    reg_sel     = wbs_adr_i[4:2];
    wr          = access & wbs_we_i;
    rd          = access & ~wbs_we_i;
    be_mask     = {{8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    wb_load_req = wr & (reg_sel == 3'd2);
    la_edge     = la_load_req & ~la_req_q;
  end

  // Read mux: sampled in the access cycle, presented with ack.
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      3'd0: rd_data[4:0]      = ctrl_q;
      3'd1: rd_data[15:0]     = presc_q;
      3'd2: rd_data[BITS-1:0] = load_q;
      3'd3: rd_data[BITS-1:0] = cmp_q;
      3'd4: begin
        rd_data[BITS-1:0] = count_q;
        rd_data[16]       = match_q;
        rd_data[17]       = pending_q;
      end
      default: rd_data = '0;
    endcase
  end

  // Register writes with byte enables
  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    load_d  = load_q;
    cmp_d   = cmp_q;
    if (wr) begin
      case (reg_sel)
        3'd0: ctrl_d  = (ctrl_q & ~be_mask[4:0]) | (wbs_dat_i[4:0] & be_mask[4:0]);
        3'd1: presc_d = (presc_q & ~be_mask) | (wbs_dat_i[15:0] & be_mask);
        3'd2: load_d  = (load_q & ~be_mask[BITS-1:0]) |
                        (wbs_dat_i[BITS-1:0] & be_mask[BITS-1:0]);
        3'd3: cmp_d   = (cmp_q & ~be_mask[BITS-1:0]) |
                        (wbs_dat_i[BITS-1:0] & be_mask[BITS-1:0]);
        default: ;
      endcase
    end
  end

  // Load arbitration FSM. A state other than IDLE means "apply that source's
  // value to the counter this cycle". The WB value lives in the LOAD register,
  // so a later LOAD write naturally overwrites a pending one.
  always_comb begin
    state_d   = ST_IDLE;
    pending_d = pending_q;
    la_val_d  = la_edge ? la_load_val : la_val_q;
    la_req_d  = la_load_req;

    // pending stays visible until its load is actually applied
    if (state_q == ST_LOAD_WB) pending_d = 1'b0;

    if (la_edge) begin
      state_d = ST_LOAD_LA;
      if (wb_load_req) pending_d = 1'b1;
    end else if (wb_load_req) begin
      state_d = ST_LOAD_WB;
    end else if (pending_q && (state_q != ST_LOAD_WB)) begin
      state_d = ST_LOAD_WB;
    end
  end

  // Prescaler, step and load application
  logic tick, step, load_apply, w1c_match;
  always_comb begin
    count_d    = count_q;
    pcnt_d     = pcnt_q;
    step       = 1'b0;
    load_apply = (state_q != ST_IDLE);
    tick       = en & (pcnt_q == presc_q);

    if (load_apply) begin
      // a load beats a coincident tick; the prescaler restarts
      count_d = (state_q == ST_LOAD_LA) ? la_val_q : load_q;
      pcnt_d  = '0;
    end else if (en) begin
      if (tick) begin
        pcnt_d = '0;
        step   = 1'b1;
        if (down) begin
          if (count_q == '0) count_d = auto_reload ? load_q : CNT_MAX;
          else               count_d = count_q - 1'b1;
        end else begin
          if (count_q == CNT_MAX) count_d = auto_reload ? load_q : '0;
          else                    count_d = count_q + 1'b1;
        end
      end else begin
        pcnt_d = pcnt_q + 16'd1;
      end
    end

    // set has priority over a same-cycle W1C
    w1c_match = wr & (reg_sel == 3'd4) & wbs_sel_i[2] & wbs_dat_i[16];
    match_d   = match_q;
    if (w1c_match) match_d = 1'b0;
    if ((load_apply || step) && (count_d == cmp_q)) match_d = 1'b1;

    irq_d = match_q & irq_en;
    ack_d = access;
    dat_d = rd ? rd_data : 32'd0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl_q    <= '0;
      presc_q   <= '0;
      load_q    <= '0;
      cmp_q     <= CNT_MAX;
      match_q   <= 1'b0;
      pending_q <= 1'b0;
      state_q   <= ST_IDLE;
      la_val_q  <= '0;
      la_req_q  <= 1'b0;
      pcnt_q    <= '0;
      count_q   <= '0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      presc_q   <= presc_d;
      load_q    <= load_d;
      cmp_q     <= cmp_d;
      match_q   <= match_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      la_val_q  <= la_val_d;
      la_req_q  <= la_req_d;
      pcnt_q    <= pcnt_d;
      count_q   <= count_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      irq_q     <= irq_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign count_o   = count_q;
  assign count_oeb = {BITS{~out_en}};
  assign irq_o     = irq_q;

`ifdef USER_COUNTER_CTRL_DIGIT_EN
  logic [6:0] digit_q, digit_d;
  logic [6:0] seg;

  always_comb begin
    case (count_q[3:0])
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    digit_d = seg ^ {7{digit_pol_in}};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) digit_q <= '0;
    else          digit_q <= digit_d;
  end

  assign digit0_out = digit_q;
  assign digit0_oeb = {7{~out_en}};

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[7:5], wbs_adr_i[1:0], wbs_sel_i[3], wbs_dat_i[31:17]};
`else
  assign digit0_out = 7'h00;
  assign digit0_oeb = 7'h7F;

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[7:5], wbs_adr_i[1:0], wbs_sel_i[3], wbs_dat_i[31:17],
                         digit_pol_in};
`endif

endmodule

// File: tb/tb_user_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_user_counter_ctrl
//
// Self-checking bench for user_counter_ctrl (BITS=16). Register reads push
// their expected data to exp_q; a monitor pops and compares when ack appears.
// Counter, IRQ and GPIO outputs are checked against cycle-exact expectations.
// -----------------------------------------------------------------------------
module tb_user_counter_ctrl;

  localparam int          BITS      = 16;
  localparam logic [23:0] ADDR_BASE = 24'h300000;

`ifdef USER_COUNTER_CTRL_DIGIT_EN
  localparam logic [6:0] EXP_DIG_POL0 = 7'h4F;
  localparam logic [6:0] EXP_DIG_POL1 = 7'h30;
  localparam logic [6:0] EXP_DIG_OEB  = 7'h00;
`else
  localparam logic [6:0] EXP_DIG_POL0 = 7'h00;
  localparam logic [6:0] EXP_DIG_POL1 = 7'h00;
  localparam logic [6:0] EXP_DIG_OEB  = 7'h7F;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            cyc, stb, we;
  logic [3:0]      sel;
  logic [31:0]     adr, dat_in;
  logic            ack;
  logic [31:0]     dat_out;
  logic            la_req;
  logic [BITS-1:0] la_val;
  logic [BITS-1:0] count_o, count_oeb;
  logic            pol;
  logic [6:0]      digit_out, digit_oeb;
  logic            irq;

  user_counter_ctrl dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (dat_in),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (dat_out),
    .la_load_req  (la_req),
    .la_load_val  (la_val),
    .count_o      (count_o),
    .count_oeb    (count_oeb),
    .digit_pol_in (pol),
    .digit0_out   (digit_out),
    .digit0_oeb   (digit_oeb),
    .irq_o        (irq)
  );

  // ---------------------------------------------------------------- scoreboard
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ack === 1'b1 && we === 1'b0) begin
      if (exp_q.size() == 0) check_eq("sb_queue", 32'(exp_q.size()), 32'd1);
      else                   check_eq("rd_data", dat_out, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- drivers
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_in = d; sel = s;
  endtask

  task automatic wb_idle();
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    wb_drive(1'b1, {ADDR_BASE, off}, d, s);
    next_cycle();
    wb_idle();
    @(negedge clk);
    check_eq("wr_ack", 32'(ack), 32'd1);
    next_cycle();
  endtask

  task automatic wb_read(input logic [7:0] off, input logic [31:0] exp);
    exp_q.push_back(exp);
    wb_drive(1'b0, {ADDR_BASE, off}, 32'd0, 4'hF);
    next_cycle();
    wb_idle();
    @(negedge clk);
    check_eq("rd_ack", 32'(ack), 32'd1);
    next_cycle();
    check_eq("rd_ack_drop", 32'(ack), 32'd0);
    check_eq("rd_dat_idle", dat_out, 32'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = '0; dat_in = '0; la_req = 1'b0; la_val = '0; pol = 1'b0;
    repeat (3) next_cycle();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    check_eq("rst_count", 32'(count_o), 32'h0);
    check_eq("rst_count_oeb", 32'(count_oeb), 32'hFFFF);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_dat", dat_out, 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_digit", 32'(digit_out), 32'h0);
    check_eq("rst_digit_oeb", 32'(digit_oeb), 32'h7F);
    next_cycle();

    // register reset values, unmapped offset, foreign base address
    wb_read(8'h00, 32'h0);
    wb_read(8'h04, 32'h0);
    wb_read(8'h08, 32'h0);
    wb_read(8'h0C, 32'h0000FFFF);
    wb_read(8'h10, 32'h0);
    wb_write(8'h14, 32'hFFFF_FFFF, 4'hF);
    wb_read(8'h14, 32'h0);
    wb_drive(1'b0, 32'h3000_0100, 32'd0, 4'hF);
    next_cycle();
    wb_idle();
    @(negedge clk);
    check_eq("bad_base_ack", 32'(ack), 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("bad_base_ack2", 32'(ack), 32'd0);
    next_cycle();

    // prescaled up-count: PRESC=3 -> one step every 4 cycles
    wb_write(8'h04, 32'd3, 4'hF);
    wb_write(8'h00, 32'h11, 4'h1);
    check_eq("count_oeb_on", 32'(count_oeb), 32'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("up_presc3", 32'(count_o), 32'((i + 1) / 4));
      next_cycle();
    end

    // down-count from 0 wraps to max
    wb_write(8'h00, 32'h10, 4'h1);
    wb_write(8'h04, 32'd0, 4'hF);
    wb_write(8'h08, 32'd0, 4'hF);
    @(negedge clk);
    check_eq("load_zero", 32'(count_o), 32'h0);
    next_cycle();
    wb_write(8'h00, 32'h13, 4'h1);
    @(negedge clk);
    check_eq("down_wrap", 32'(count_o), 32'hFFFF);
    next_cycle();
    @(negedge clk);
    check_eq("down_step", 32'(count_o), 32'hFFFE);
    next_cycle();
    wb_write(8'h00, 32'h10, 4'h1);
    wb_write(8'h10, 32'h0001_0000, 4'h4);
    wb_read(8'h10, 32'h0000_FFFC);

    // WB LOAD and LA edge in the same cycle: LA first, WB one cycle later
    la_val = 16'hABCD;
    la_req = 1'b1;
    wb_drive(1'b1, {ADDR_BASE, 8'h08}, 32'h1234, 4'hF);
    next_cycle();
    wb_idle();
    @(negedge clk);
    check_eq("coll_wr_ack", 32'(ack), 32'd1);
    next_cycle();
    exp_q.push_back(32'h0002_ABCD);
    wb_drive(1'b0, {ADDR_BASE, 8'h10}, 32'd0, 4'hF);
    @(negedge clk);
    check_eq("coll_la_first", 32'(count_o), 32'hABCD);
    next_cycle();
    wb_idle();
    @(negedge clk);
    check_eq("coll_rd_ack", 32'(ack), 32'd1);
    check_eq("coll_wb_second", 32'(count_o), 32'h1234);
    next_cycle();
    la_req = 1'b0;
    wb_read(8'h10, 32'h0000_1234);
    wb_read(8'h08, 32'h0000_1234);

    // compare match and IRQ (up-count with irq_en)
    wb_write(8'h0C, 32'h10, 4'h3);
    wb_write(8'h08, 32'h0E, 4'h3);
    wb_write(8'h00, 32'h15, 4'h1);
    @(negedge clk);
    check_eq("cmp_cnt_0f", 32'(count_o), 32'h0F);
    check_eq("cmp_irq_0f", 32'(irq), 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("cmp_cnt_10", 32'(count_o), 32'h10);
    check_eq("cmp_irq_10", 32'(irq), 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("cmp_cnt_11", 32'(count_o), 32'h11);
    check_eq("cmp_irq_set", 32'(irq), 32'd1);
    next_cycle();
    wb_write(8'h00, 32'h14, 4'h1);
    @(negedge clk);
    check_eq("irq_held", 32'(irq), 32'd1);
    next_cycle();
    wb_read(8'h10, 32'h0001_0013);
    wb_write(8'h10, 32'h0001_0000, 4'h4);
    check_eq("irq_w1c", 32'(irq), 32'd0);
    wb_read(8'h10, 32'h0000_0013);

    // auto-reload on wrap
    wb_write(8'h08, 32'hFFF0, 4'h3);
    la_val = 16'hFFFE;
    la_req = 1'b1;
    repeat (3) next_cycle();
    la_req = 1'b0;
    @(negedge clk);
    check_eq("la_load", 32'(count_o), 32'hFFFE);
    next_cycle();
    wb_write(8'h00, 32'h19, 4'h1);
    @(negedge clk);
    check_eq("ar_ffff", 32'(count_o), 32'hFFFF);
    next_cycle();
    @(negedge clk);
    check_eq("ar_reload", 32'(count_o), 32'hFFF0);
    next_cycle();
    @(negedge clk);
    check_eq("ar_step", 32'(count_o), 32'hFFF1);
    next_cycle();

    // reset in the middle of a write: no ack, register not written
    wb_drive(1'b1, {ADDR_BASE, 8'h0C}, 32'h5555, 4'hF);
    rst = 1'b1;
    next_cycle();
    wb_idle();
    @(negedge clk);
    check_eq("midrst_ack", 32'(ack), 32'd0);
    check_eq("midrst_count", 32'(count_o), 32'h0);
    next_cycle();
    rst = 1'b0;
    wb_read(8'h0C, 32'h0000_FFFF);
    wb_read(8'h00, 32'h0);

    // 7-segment digit
    wb_write(8'h00, 32'h10, 4'h1);
    la_val = 16'h0003;
    la_req = 1'b1;
    repeat (4) next_cycle();
    la_req = 1'b0;
    pol = 1'b0;
    @(negedge clk);
    check_eq("dig_count", 32'(count_o), 32'h3);
    check_eq("dig_pol0", 32'(digit_out), 32'(EXP_DIG_POL0));
    check_eq("dig_oeb", 32'(digit_oeb), 32'(EXP_DIG_OEB));
    next_cycle();
    pol = 1'b1;
    next_cycle();
    @(negedge clk);
    check_eq("dig_pol1", 32'(digit_out), 32'(EXP_DIG_POL1));
    next_cycle();

    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
